dr_arbiter: RTL and testbench

DR_ARBITER -- requirements
Module: dr_arbiter

---
 rtl/dr_arb_pkg.sv | 23 ++
 rtl/dr_arb_pick.sv | 32 +++
 rtl/dr_arbiter.sv | 132 +++++++++++++
 tb/tb_dr_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dr_arb_pkg.sv
// dr_arb_pkg -- shared types and constants for the two-port data-register
// arbiter.
//   cmd_t   : requester command encoding (NOP / LOAD / INCREMENT / CLEAR)
//   state_t : arbiter FSM states (IDLE / SERVE / WAIT)
//   DR_W    : width of the shared data register and of the load data
package dr_arb_pkg;

  localparam int DR_W = 16;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_LOAD = 2'b01,
    CMD_INC  = 2'b10,
    CMD_CLR  = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

endpackage

// File: rtl/dr_arb_pick.sv
// dr_arb_pick -- combinational winner selection for the two requesters.
// Optional feature macro: DR_ARB_RR_EN
//   defined   : round-robin; on a tie the requester named by ptr wins
//   undefined : fixed priority; req0 always beats req1, ptr is ignored
// Ports:
//   req0, req1 : request bits
//   ptr        : round-robin pointer (index of the favoured requester)
//   valid      : at least one request present
//   idx        : winning requester index (0 when valid is low)
module dr_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic valid,
  output logic idx
);

  assign valid = req0 | req1;

`ifdef DR_ARB_RR_EN
  // Tie goes to the pointer; otherwise the lone requester wins.
  assign idx = (req0 & req1) ? ptr : req1;
`else
  // Fixed priority: requester 1 wins only when requester 0 is idle.
  assign idx = req1 & ~req0;

  // The pointer has no role here; it is absorbed so the port stays uniform.
  logic unused_ptr;
  assign unused_ptr = ptr;
`endif

endmodule

// File: rtl/dr_arbiter.sv
// dr_arbiter -- arbitrates two requesters for a shared 16-bit data register.
// A request seen in IDLE is granted for one SERVE cycle (one command strobe),
// then held in WAIT until the winner drops its request. All outputs are
// registered. Arbitration policy is chosen in dr_arb_pick (macro DR_ARB_RR_EN).
// Ports:
//   CLK, CLR_N            : clock, asynchronous active-low reset
//   REQ0/REQ1             : requests, held until the matching GNT is seen
//   CMD0/CMD1             : commands (NOP, LOAD, INCREMENT, CLEAR)
//   DATA0/DATA1           : load values
//   GNT0/GNT1             : grants, held until the requester drops REQ
//   DR_LD, DR_INR, DR_CLR : one-cycle command strobes to the data register
//   DR_IN                 : load value to the data register
//   OWNER                 : index of the current or last granted requester
//   BUSY                  : high whenever the FSM is not IDLE
module dr_arbiter
  import dr_arb_pkg::*;
(
  input  logic            CLK,
  input  logic            CLR_N,
  input  logic            REQ0,
  input  logic            REQ1,
  input  logic [1:0]      CMD0,
  input  logic [1:0]      CMD1,
  input  logic [DR_W-1:0] DATA0,
  input  logic [DR_W-1:0] DATA1,
  output logic            GNT0,
  output logic            GNT1,
  output logic            DR_LD,
  output logic            DR_INR,
  output logic            DR_CLR,
  output logic [DR_W-1:0] DR_IN,
  output logic            OWNER,
  output logic            BUSY
);

  state_t          state, state_nxt;
  logic            ptr, ptr_nxt;
  logic            pick_valid, pick_idx;
  logic            gnt0_nxt, gnt1_nxt;
  logic            ld_nxt, inr_nxt, clr_nxt;
  logic [DR_W-1:0] dr_in_nxt;
  logic            owner_nxt, busy_nxt;
  cmd_t            sel_cmd;
  logic [DR_W-1:0] sel_data;
  logic            owner_req;

  dr_arb_pick u_pick (
    .req0  (REQ0),
    .req1  (REQ1),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Command and data of the candidate winner, used only on the grant edge.
  assign sel_cmd   = cmd_t'(pick_idx ? CMD1 : CMD0);
  assign sel_data  = pick_idx ? DATA1 : DATA0;
  assign owner_req = OWNER ? REQ1 : REQ0;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt0_nxt  = GNT0;
    gnt1_nxt  = GNT1;
    ld_nxt    = 1'b0;
    inr_nxt   = 1'b0;
    clr_nxt   = 1'b0;
    dr_in_nxt = DR_IN;
    owner_nxt = OWNER;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt = ST_SERVE;
          owner_nxt = pick_idx;
          // After every grant the other requester is favoured next time.
          ptr_nxt   = ~pick_idx;
          gnt0_nxt  = ~pick_idx;
          gnt1_nxt  = pick_idx;
          dr_in_nxt = sel_data;
          case (sel_cmd)
            CMD_LOAD: ld_nxt  = 1'b1;
            CMD_INC:  inr_nxt = 1'b1;
            CMD_CLR:  clr_nxt = 1'b1;
            default:  ;
          endcase
        end
      end
      ST_SERVE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // Grant is released on the edge where the winner's request is low.
        if (!owner_req) begin
          state_nxt = ST_IDLE;
          gnt0_nxt  = 1'b0;
          gnt1_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state  <= ST_IDLE;
      ptr    <= 1'b0;
      GNT0   <= 1'b0;
      GNT1   <= 1'b0;
      DR_LD  <= 1'b0;
      DR_INR <= 1'b0;
      DR_CLR <= 1'b0;
      DR_IN  <= '0;
      OWNER  <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      GNT0   <= gnt0_nxt;
      GNT1   <= gnt1_nxt;
      DR_LD  <= ld_nxt;
      DR_INR <= inr_nxt;
      DR_CLR <= clr_nxt;
      DR_IN  <= dr_in_nxt;
      OWNER  <= owner_nxt;
      BUSY   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_dr_arbiter.sv
// tb_dr_arbiter -- directed self-checking bench for dr_arbiter, followed by a
// random-traffic section checking grant/strobe invariants. Expected values
// follow the macro DR_ARB_RR_EN where the policy matters.
// Output vector order in checks: {GNT0, GNT1, DR_LD, DR_INR, DR_CLR, OWNER, BUSY}
module tb_dr_arbiter;

  logic        CLK = 1'b0;
  logic        CLR_N;
  logic        REQ0, REQ1;
  logic [1:0]  CMD0, CMD1;
  logic [15:0] DATA0, DATA1;
  logic        GNT0, GNT1, DR_LD, DR_INR, DR_CLR, OWNER, BUSY;
  logic [15:0] DR_IN;

  int checkCount = 0;
  int failCount  = 0;

  localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, INC = 2'b10, CLR = 2'b11;

  localparam logic [6:0] V_IDLE0   = 7'b0000000;
  localparam logic [6:0] V_IDLE1   = 7'b0000010;
  localparam logic [6:0] V_S0_LD   = 7'b1010001;
  localparam logic [6:0] V_S0_INR  = 7'b1001001;
  localparam logic [6:0] V_S0_CLR  = 7'b1000101;
  localparam logic [6:0] V_W0      = 7'b1000001;
  localparam logic [6:0] V_S1_LD   = 7'b0110011;
  localparam logic [6:0] V_S1_CLR  = 7'b0100111;
  localparam logic [6:0] V_W1      = 7'b0100011;

  dr_arbiter dut (
    .CLK    (CLK),
    .CLR_N  (CLR_N),
    .REQ0   (REQ0),
    .REQ1   (REQ1),
    .CMD0   (CMD0),
    .CMD1   (CMD1),
    .DATA0  (DATA0),
    .DATA1  (DATA1),
    .GNT0   (GNT0),
    .GNT1   (GNT1),
    .DR_LD  (DR_LD),
    .DR_INR (DR_INR),
    .DR_CLR (DR_CLR),
    .DR_IN  (DR_IN),
    .OWNER  (OWNER),
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkVec(input string tag, input logic [6:0] expected);
    checkOutput(tag, {25'b0, GNT0, GNT1, DR_LD, DR_INR, DR_CLR, OWNER, BUSY},
                {25'b0, expected});
  endtask

  task automatic applyStimulus(input logic r0, input logic [1:0] c0,
                               input logic [15:0] d0, input logic r1,
                               input logic [1:0] c1, input logic [15:0] d1);
    REQ0 = r0; CMD0 = c0; DATA0 = d0;
    REQ1 = r1; CMD1 = c1; DATA1 = d1;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    CLR_N = 1'b0;
    applyStimulus(0, NOP, 16'h0, 0, NOP, 16'h0);
    tick();
    tick();
    CLR_N = 1'b1;
  endtask

  logic prevStrobe;
  logic anyStrobe;

  initial begin
    CLR_N = 1'b0;
    applyStimulus(0, NOP, 16'h0, 0, NOP, 16'h0);
    #3;
    checkVec("resetVec", V_IDLE0);
    checkOutput("resetDrIn", DR_IN, 16'h0);
    tick();
    tick();
    CLR_N = 1'b1;
    tick();
    checkVec("idleAfterRelease", V_IDLE0);

    // Single LOAD from requester 0
    applyStimulus(1, LOAD, 16'hA5C3, 0, NOP, 16'h0);
    tick();
    checkVec("loadServe", V_S0_LD);
    checkOutput("loadDrIn", DR_IN, 16'hA5C3);
    tick();
    checkVec("loadWait", V_W0);
    tick();
    checkVec("loadWaitHeld", V_W0);
    applyStimulus(0, LOAD, 16'hA5C3, 0, NOP, 16'h0);
    tick();
    checkVec("loadIdle", V_IDLE0);
    checkOutput("loadDrInHold", DR_IN, 16'hA5C3);

    // Simultaneous requests from reset
    doReset();
    tick();
    checkVec("simResetIdle", V_IDLE0);
    applyStimulus(1, INC, 16'h1111, 1, CLR, 16'h2222);
    tick();
    checkVec("simFirstServe", V_S0_INR);
    checkOutput("simFirstDrIn", DR_IN, 16'h1111);
    tick();
    checkVec("simFirstWait", V_W0);
    applyStimulus(0, INC, 16'h1111, 1, CLR, 16'h2222);
    tick();
    checkVec("simFirstIdle", V_IDLE0);
    applyStimulus(1, INC, 16'h1111, 1, CLR, 16'h2222);
    tick();
`ifdef DR_ARB_RR_EN
    checkVec("simSecondServe", V_S1_CLR);
    tick();
    checkVec("simSecondWait", V_W1);
    applyStimulus(1, INC, 16'h1111, 0, CLR, 16'h2222);
    tick();
    checkVec("simSecondIdle", V_IDLE1);
    tick();
    checkVec("simThirdServe", V_S0_INR);
    tick();
    checkVec("simThirdWait", V_W0);
    applyStimulus(0, NOP, 16'h0, 0, NOP, 16'h0);
    tick();
    checkVec("simThirdIdle", V_IDLE0);
`else
    checkVec("simSecondServe", V_S0_INR);
    tick();
    checkVec("simSecondWait", V_W0);
    applyStimulus(0, INC, 16'h1111, 1, CLR, 16'h2222);
    tick();
    checkVec("simSecondIdle", V_IDLE0);
    tick();
    checkVec("simThirdServe", V_S1_CLR);
    checkOutput("simThirdDrIn", DR_IN, 16'h2222);
    tick();
    checkVec("simThirdWait", V_W1);
    applyStimulus(0, NOP, 16'h0, 0, NOP, 16'h0);
    tick();
    checkVec("simThirdIdle", V_IDLE1);
`endif

    // NOP grant to requester 1, held for 5 cycles with requester 0 pending
    applyStimulus(0, NOP, 16'h0, 1, NOP, 16'h00FF);
    tick();
    checkVec("nopServe", V_W1);
    checkOutput("nopDrIn", DR_IN, 16'h00FF);
    applyStimulus(1, LOAD, 16'h1234, 1, NOP, 16'h00FF);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkVec("heldWait", V_W1);
    end
    applyStimulus(1, LOAD, 16'h1234, 0, NOP, 16'h00FF);
    tick();
    checkVec("heldRelease", V_IDLE1);
    tick();
    checkVec("pendingServe", V_S0_LD);
    checkOutput("pendingDrIn", DR_IN, 16'h1234);
    tick();
    checkVec("pendingWait", V_W0);
    applyStimulus(0, NOP, 16'h0, 0, NOP, 16'h0);
    tick();
    checkVec("pendingIdle", V_IDLE0);

    // Requester 0 raised and dropped while requester 1 is served
    applyStimulus(0, NOP, 16'h0, 1, LOAD, 16'hBEEF);
    tick();
    checkVec("cancelServe", V_S1_LD);
    applyStimulus(1, CLR, 16'h0, 1, LOAD, 16'hBEEF);
    tick();
    checkVec("cancelWait", V_W1);
    applyStimulus(0, CLR, 16'h0, 0, LOAD, 16'hBEEF);
    tick();
    checkVec("cancelIdle", V_IDLE1);
    tick();
    checkVec("cancelNoGnt0", V_IDLE1);
    checkOutput("cancelDrIn", DR_IN, 16'hBEEF);

    // Reset asserted mid-SERVE with both requesters active
    applyStimulus(1, CLR, 16'h5555, 1, INC, 16'h6666);
    tick();
    checkVec("rstPreServe", V_S0_CLR);
    #2;
    CLR_N = 1'b0;
    #1;
    checkVec("rstMidServe", V_IDLE0);
    checkOutput("rstDrIn", DR_IN, 16'h0);
    applyStimulus(0, NOP, 16'h0, 0, NOP, 16'h0);
    tick();
    CLR_N = 1'b1;
    tick();
    checkVec("rstNoReplay", V_IDLE0);

    // Random traffic: grant/strobe invariants every cycle
    prevStrobe = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (GNT0) REQ0 = ($urandom_range(0, 1) == 1);
      else if (!REQ0) begin
        REQ0 = ($urandom_range(0, 2) == 0);
        CMD0 = 2'($urandom_range(0, 3));
        DATA0 = 16'($urandom);
      end
      if (GNT1) REQ1 = ($urandom_range(0, 1) == 1);
      else if (!REQ1) begin
        REQ1 = ($urandom_range(0, 2) == 0);
        CMD1 = 2'($urandom_range(0, 3));
        DATA1 = 16'($urandom);
      end
      tick();
      anyStrobe = DR_LD | DR_INR | DR_CLR;
      checkOutput("gntExclusive", {31'b0, GNT0 & GNT1}, 32'h0);
      checkOutput("strobeOneHot", ($countones({DR_LD, DR_INR, DR_CLR}) > 1) ? 32'h1 : 32'h0,
                  32'h0);
      checkOutput("strobeOneCycle", {31'b0, prevStrobe & anyStrobe}, 32'h0);
      prevStrobe = anyStrobe;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
